// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_stage
//  Description : Registered RV32I/RV64I immediate decode stage. Classifies the
//                instruction format, extracts register indices and the
//                sign-extended immediate, and presents pc + imm. Valid/ready on
//                both sides with a one-entry skid buffer for full throughput.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_target
);

    // Shift amounts are 6 bits wide on RV64, 5 bits on RV32.
    localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    localparam logic [2:0] c_FMT_R   = 3'd0;
    localparam logic [2:0] c_FMT_I   = 3'd1;
    localparam logic [2:0] c_FMT_S   = 3'd2;
    localparam logic [2:0] c_FMT_B   = 3'd3;
    localparam logic [2:0] c_FMT_U   = 3'd4;
    localparam logic [2:0] c_FMT_J   = 3'd5;
    localparam logic [2:0] c_FMT_ILL = 3'd7;

    // Stored entry: {pc, imm, rs1, rs2, rd, fmt, illegal}
    localparam int c_ENTRY_W = 2 * XLEN + 19;

    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic [31:0]           w_imm32;
    logic [XLEN-1:0]       w_imm;
    logic [4:0]            w_rs1;
    logic [4:0]            w_rs2;
    logic [4:0]            w_rd;
    logic [2:0]            w_fmt;
    logic                  w_illegal;
    logic [c_ENTRY_W-1:0]  w_in_entry;
    logic                  w_accept;
    logic                  w_main_free;
    logic [XLEN-1:0]       w_main_pc;

    logic                  r_main_valid;
    logic                  r_skid_valid;
    logic [c_ENTRY_W-1:0]  r_main_entry;
    logic [c_ENTRY_W-1:0]  r_skid_entry;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];

    // Format classification and 32-bit immediate assembly from the raw word.
    always_comb begin
        w_imm32   = 32'd0;
        w_rs1     = 5'd0;
        w_rs2     = 5'd0;
        w_rd      = 5'd0;
        w_fmt     = c_FMT_ILL;
        w_illegal = 1'b1;
        case (w_opcode)
            c_OP_REG: begin
                w_fmt     = c_FMT_R;
                w_illegal = 1'b0;
                w_rs1     = in_instr[19:15];
                w_rs2     = in_instr[24:20];
                w_rd      = in_instr[11:7];
            end
            c_OP_IMM, c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM: begin
                w_fmt     = c_FMT_I;
                w_illegal = 1'b0;
                w_rs1     = in_instr[19:15];
                w_rd      = in_instr[11:7];
                // slli/srli/srai carry a plain shift amount, never sign-extended;
                // srai's funct7 bit is deliberately dropped here.
                if ((w_opcode == c_OP_IMM) &&
                    ((w_funct3 == 3'b001) || (w_funct3 == 3'b101))) begin
                    w_imm32 = 32'(in_instr[20 +: SHAMT_W]);
                end else begin
                    w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            c_OP_STORE: begin
                w_fmt     = c_FMT_S;
                w_illegal = 1'b0;
                w_rs1     = in_instr[19:15];
                w_rs2     = in_instr[24:20];
                w_imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            c_OP_BRANCH: begin
                w_fmt     = c_FMT_B;
                w_illegal = 1'b0;
                w_rs1     = in_instr[19:15];
                w_rs2     = in_instr[24:20];
                w_imm32   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_fmt     = c_FMT_U;
                w_illegal = 1'b0;
                w_rd      = in_instr[11:7];
                w_imm32   = {in_instr[31:12], 12'd0};
            end
            c_OP_JAL: begin
                w_fmt     = c_FMT_J;
                w_illegal = 1'b0;
                w_rd      = in_instr[11:7];
                w_imm32   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
            end
            default: begin
                w_fmt     = c_FMT_ILL;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Every 32-bit immediate is a correctly signed value (shift amounts have
    // bit 31 clear), so one signed widening covers all formats on RV64.
    assign w_imm      = XLEN'($signed(w_imm32));
    assign w_in_entry = {in_pc, w_imm, w_rs1, w_rs2, w_rd, w_fmt, w_illegal};

    // in_ready comes straight from the skid flop, so it never sees out_ready.
    assign in_ready    = ~r_skid_valid;
    assign w_accept    = in_valid & ~r_skid_valid;
    assign w_main_free = ~r_main_valid | out_ready;

    // Main/skid storage: main refills from skid first (FIFO order), otherwise
    // from the input; skid only captures while main is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_entry <= '0;
            r_skid_entry <= '0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_entry <= r_skid_entry;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main_entry <= w_in_entry;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_entry <= w_in_entry;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid = r_main_valid;
    assign {w_main_pc, out_imm, out_rs1, out_rs2, out_rd, out_fmt, out_illegal} = r_main_entry;
    assign out_target = w_main_pc + out_imm;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_stage
//  Description : Self-checking bench for imm_gen_stage, XLEN=32 and XLEN=64
//                instances driven by the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        rdy32, ov32, ill32;
    logic [31:0] imm32, tgt32;
    logic [4:0]  rs1_32, rs2_32, rd32;
    logic [2:0]  fmt32;

    logic        rdy64, ov64, ill64;
    logic [63:0] imm64, tgt64;
    logic [4:0]  rs1_64, rs2_64, rd64;
    logic [2:0]  fmt64;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  fmt;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
    } txn_t;

    txn_t q[$];

    imm_gen_stage #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(ov32), .out_ready(out_ready),
        .out_imm(imm32), .out_rs1(rs1_32), .out_rs2(rs2_32), .out_rd(rd32),
        .out_fmt(fmt32), .out_illegal(ill32), .out_target(tgt32)
    );

    imm_gen_stage #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(ov64), .out_ready(out_ready),
        .out_imm(imm64), .out_rs1(rs1_64), .out_rs2(rs2_64), .out_rd(rd64),
        .out_fmt(fmt64), .out_illegal(ill64), .out_target(tgt64)
    );

    always #5 clk = ~clk;

    // Reference decode: immediates computed as signed integers from the
    // bit-field weights, then reduced modulo 2^xlen.
    function automatic dec_t ref_dec(input logic [31:0] ins, input int xlen);
        dec_t   d;
        longint x;
        longint v;
        int     op;
        int     f3;
        x  = longint'({32'd0, ins});
        op = int'(x & 127);
        f3 = int'((x >> 12) & 7);
        v  = 0;
        d.rs1 = 5'd0; d.rs2 = 5'd0; d.rd = 5'd0; d.fmt = 3'd7; d.ill = 1'b1;
        if (op == 'h33) begin
            d.fmt = 3'd0; d.ill = 1'b0;
            d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.rd = ins[11:7];
        end else if (op == 'h13 || op == 'h03 || op == 'h67 || op == 'h73) begin
            d.fmt = 3'd1; d.ill = 1'b0;
            d.rs1 = ins[19:15]; d.rd = ins[11:7];
            if (op == 'h13 && (f3 == 1 || f3 == 5)) begin
                v = (x >> 20) % ((xlen == 64) ? 64 : 32);
            end else begin
                v = x >> 20;
                if (v >= 2048) v = v - 4096;
            end
        end else if (op == 'h23) begin
            d.fmt = 3'd2; d.ill = 1'b0;
            d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
            v = ((x >> 25) & 127) * 32 + ((x >> 7) & 31);
            if (v >= 2048) v = v - 4096;
        end else if (op == 'h63) begin
            d.fmt = 3'd3; d.ill = 1'b0;
            d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
            v = ((x >> 7) & 1) * 2048 + ((x >> 25) & 63) * 32 + ((x >> 8) & 15) * 2;
            if (((x >> 31) & 1) == 1) v = v - 4096;
        end else if (op == 'h37 || op == 'h17) begin
            d.fmt = 3'd4; d.ill = 1'b0;
            d.rd = ins[11:7];
            v = (x >> 12) * 4096;
            if (((x >> 31) & 1) == 1) v = v - longint'(64'h1_0000_0000);
        end else if (op == 'h6F) begin
            d.fmt = 3'd5; d.ill = 1'b0;
            d.rd = ins[11:7];
            v = ((x >> 12) & 255) * 4096 + ((x >> 20) & 1) * 2048 + ((x >> 21) & 1023) * 2;
            if (((x >> 31) & 1) == 1) v = v - 1048576;
        end
        d.imm = (xlen == 32) ? (64'(v) & 64'h0000_0000_FFFF_FFFF) : 64'(v);
        return d;
    endfunction

    function automatic logic [63:0] ref_tgt(input logic [63:0] pc, input logic [63:0] imm,
                                            input int xlen);
        logic [63:0] t;
        t = pc + imm;
        return (xlen == 32) ? (t & 64'h0000_0000_FFFF_FFFF) : t;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [12];
        logic [31:0] ins;
        int          k;
        ops = '{7'h33, 7'h13, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h7F};
        ins = $urandom;
        k   = $urandom_range(0, 11);
        ins[6:0] = ops[k];
        if (ops[k] == 7'h13 && $urandom_range(0, 1) == 1)
            ins[14:12] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101;
        if ($urandom_range(0, 9) == 0) ins[6:0] = 7'h00;
        return ins;
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    // Drive one instruction; returns at the negedge after it was accepted.
    task automatic send_one(input logic [31:0] ins, input logic [63:0] pc);
        @(negedge clk);
        in_valid = 1'b1; in_instr = ins; in_pc = pc; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if ({ov32, rdy32} !== 2'b01) begin
            n_fail++; $display("FAIL reset_hs32: got valid/ready=%b%b need 01", ov32, rdy32);
        end
        n_tests++;
        if ({ov64, rdy64} !== 2'b01) begin
            n_fail++; $display("FAIL reset_hs64: got valid/ready=%b%b need 01", ov64, rdy64);
        end
        n_tests++;
        if ({imm32, tgt32, rs1_32, rs2_32, rd32, fmt32, ill32} !== '0) begin
            n_fail++; $display("FAIL reset_data32: got imm=%h tgt=%h fmt=%0d need all 0", imm32, tgt32, fmt32);
        end
        n_tests++;
        if ({imm64, tgt64, rs1_64, rs2_64, rd64, fmt64, ill64} !== '0) begin
            n_fail++; $display("FAIL reset_data64: got imm=%h tgt=%h fmt=%0d need all 0", imm64, tgt64, fmt64);
        end
    endtask

    task automatic test_formats();
        send_one(32'h00500093, 64'h0);
        n_tests++;
        if ({ov32, fmt32, imm32, rd32, rs1_32, tgt32} !== {1'b1, 3'd1, 32'd5, 5'd1, 5'd0, 32'd5}) begin
            n_fail++; $display("FAIL addi32: got v=%b fmt=%0d imm=%h rd=%0d rs1=%0d tgt=%h need 1/1/5/1/0/5",
                               ov32, fmt32, imm32, rd32, rs1_32, tgt32);
        end
        send_one(32'hFE000EE3, 64'h100);
        n_tests++;
        if ({fmt32, imm32, rd32, tgt32} !== {3'd3, 32'hFFFF_FFFC, 5'd0, 32'hFC}) begin
            n_fail++; $display("FAIL beq32: got fmt=%0d imm=%h rd=%0d tgt=%h need 3/fffffffc/0/fc",
                               fmt32, imm32, rd32, tgt32);
        end
        n_tests++;
        if ({imm64, tgt64} !== {64'hFFFF_FFFF_FFFF_FFFC, 64'hFC}) begin
            n_fail++; $display("FAIL beq64: got imm=%h tgt=%h need fffffffffffffffc/fc", imm64, tgt64);
        end
        send_one(32'hFE512C23, 64'h0);
        n_tests++;
        if ({fmt32, imm32, rs1_32, rs2_32, rd32} !== {3'd2, 32'hFFFF_FFF8, 5'd2, 5'd5, 5'd0}) begin
            n_fail++; $display("FAIL sw32: got fmt=%0d imm=%h rs1=%0d rs2=%0d rd=%0d need 2/fffffff8/2/5/0",
                               fmt32, imm32, rs1_32, rs2_32, rd32);
        end
        send_one(32'hFFFF_FFFF, 64'h40);
        n_tests++;
        if ({fmt32, ill32, imm32, rs1_32, rs2_32, rd32} !== {3'd7, 1'b1, 32'd0, 15'd0}) begin
            n_fail++; $display("FAIL illegal32: got fmt=%0d ill=%b imm=%h regs=%0d/%0d/%0d need 7/1/0/0",
                               fmt32, ill32, imm32, rs1_32, rs2_32, rd32);
        end
        n_tests++;
        if ({fmt64, ill64, imm64} !== {3'd7, 1'b1, 64'd0}) begin
            n_fail++; $display("FAIL illegal64: got fmt=%0d ill=%b imm=%h need 7/1/0", fmt64, ill64, imm64);
        end
    endtask

    task automatic test_xlen64();
        send_one(32'h80000037, 64'h0);
        n_tests++;
        if ({fmt64, imm64} !== {3'd4, 64'hFFFF_FFFF_8000_0000}) begin
            n_fail++; $display("FAIL lui64: got fmt=%0d imm=%h need 4/ffffffff80000000", fmt64, imm64);
        end
        n_tests++;
        if (imm32 !== 32'h8000_0000) begin
            n_fail++; $display("FAIL lui32: got imm=%h need 80000000", imm32);
        end
        send_one(32'h03F0D093, 64'h0);
        n_tests++;
        if ({fmt64, imm64} !== {3'd1, 64'd63}) begin
            n_fail++; $display("FAIL srli64: got fmt=%0d imm=%h need 1/3f", fmt64, imm64);
        end
        n_tests++;
        if (imm32 !== 32'd31) begin
            n_fail++; $display("FAIL srli32: got imm=%h need 1f", imm32);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h0;
        @(negedge clk);
        n_tests++;
        if ({ov32, imm32, rdy32} !== {1'b1, 32'd1, 1'b1}) begin
            n_fail++; $display("FAIL bp_first: got v=%b imm=%h rdy=%b need 1/1/1", ov32, imm32, rdy32);
        end
        in_instr = 32'h00200093;
        @(negedge clk);
        n_tests++;
        if ({ov32, imm32, rdy32, rdy64} !== {1'b1, 32'd1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL bp_full: got v=%b imm=%h rdy32=%b rdy64=%b need 1/1/0/0",
                               ov32, imm32, rdy32, rdy64);
        end
        in_instr = 32'h00300093;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if ({ov32, imm32, rdy32} !== {1'b1, 32'd1, 1'b0}) begin
                n_fail++; $display("FAIL bp_hold%0d: got v=%b imm=%h rdy=%b need 1/1/0", i, ov32, imm32, rdy32);
            end
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (rdy32 !== 1'b0) begin
            n_fail++; $display("FAIL bp_comb_ready: got rdy=%b need 0", rdy32);
        end
        @(negedge clk);
        n_tests++;
        if ({ov32, imm32, rdy32} !== {1'b1, 32'd2, 1'b1}) begin
            n_fail++; $display("FAIL bp_second: got v=%b imm=%h rdy=%b need 1/2/1", ov32, imm32, rdy32);
        end
        @(negedge clk);
        n_tests++;
        if ({ov32, imm32} !== {1'b1, 32'd3}) begin
            n_fail++; $display("FAIL bp_third: got v=%b imm=%h need 1/3", ov32, imm32);
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ov32 !== 1'b0) begin
            n_fail++; $display("FAIL bp_empty: got v=%b need 0", ov32);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_tests++;
                if ({ov32, imm32, rdy32} !== {1'b1, 32'(k + 9), 1'b1}) begin
                    n_fail++; $display("FAIL stream%0d: got v=%b imm=%h rdy=%b need 1/%h/1",
                                       k, ov32, imm32, rdy32, 32'(k + 9));
                end
            end
            in_valid = 1'b1;
            in_instr = 32'h00000093 | (32'(k + 10) << 20);
        end
        @(negedge clk);
        n_tests++;
        if ({ov32, imm32} !== {1'b1, 32'd17}) begin
            n_fail++; $display("FAIL stream_last: got v=%b imm=%h need 1/11", ov32, imm32);
        end
        // Fill main and skid, then reset between edges.
        out_ready = 1'b0;
        in_instr  = 32'h00700093;
        @(negedge clk);
        in_instr  = 32'h00800093;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({ov32, rdy32, ov64, rdy64} !== 4'b0101) begin
            n_fail++; $display("FAIL rst_mid: got v32=%b r32=%b v64=%b r64=%b need 0/1/0/1",
                               ov32, rdy32, ov64, rdy64);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if ({ov32, ov64} !== 2'b00) begin
                n_fail++; $display("FAIL rst_no_pulse%0d: got v32=%b v64=%b need 0/0", i, ov32, ov64);
            end
        end
    endtask

    task automatic test_random();
        txn_t t;
        dec_t e32, e64;
        logic [63:0] x32, x64;
        int sz;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            sz = q.size();
            n_tests++;
            if ({ov32, rdy32, ov64, rdy64} !== {sz > 0, sz < 2, sz > 0, sz < 2}) begin
                n_fail++; $display("FAIL rand_hs c%0d: got v32=%b r32=%b v64=%b r64=%b occ=%0d",
                                   cyc, ov32, rdy32, ov64, rdy64, sz);
            end
            if (sz > 0) begin
                t   = q[0];
                e32 = ref_dec(t.ins, 32);
                e64 = ref_dec(t.ins, 64);
                x32 = ref_tgt(t.pc, e32.imm, 32);
                x64 = ref_tgt(t.pc, e64.imm, 64);
                n_tests++;
                if ({imm32, rs1_32, rs2_32, rd32, fmt32, ill32, tgt32} !==
                    {e32.imm[31:0], e32.rs1, e32.rs2, e32.rd, e32.fmt, e32.ill, x32[31:0]}) begin
                    n_fail++; $display("FAIL rand32 c%0d ins=%h: got imm=%h regs=%0d/%0d/%0d fmt=%0d ill=%b tgt=%h need imm=%h regs=%0d/%0d/%0d fmt=%0d ill=%b tgt=%h",
                        cyc, t.ins, imm32, rs1_32, rs2_32, rd32, fmt32, ill32, tgt32,
                        e32.imm[31:0], e32.rs1, e32.rs2, e32.rd, e32.fmt, e32.ill, x32[31:0]);
                end
                n_tests++;
                if ({imm64, rs1_64, rs2_64, rd64, fmt64, ill64, tgt64} !==
                    {e64.imm, e64.rs1, e64.rs2, e64.rd, e64.fmt, e64.ill, x64}) begin
                    n_fail++; $display("FAIL rand64 c%0d ins=%h: got imm=%h fmt=%0d ill=%b tgt=%h need imm=%h fmt=%0d ill=%b tgt=%h",
                        cyc, t.ins, imm64, fmt64, ill64, tgt64, e64.imm, e64.fmt, e64.ill, x64);
                end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_instr  = rand_instr();
            in_pc     = {$urandom, $urandom};
            if (sz > 0 && out_ready) void'(q.pop_front());
            if (in_valid && sz < 2) begin
                t.ins = in_instr;
                t.pc  = in_pc;
                q.push_back(t);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_formats();
        test_xlen64();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
